// File: rtl/ram_port_arbiter.sv
// Shares the single-port RAM between the CPU bus channel and NUM_CH-1 other requesters.
// Non-CPU grants are issued only after the CPU has been held off through RDY.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 3,
  parameter int CPU_CH     = 1,
  parameter int RR_MODE    = 0,
  parameter int HALT_EDGES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load_done,
  input  logic                         phi2,
  input  logic [NUM_CH-1:0]            ch_req,
  input  logic [NUM_CH-1:0]            ch_cs,
  input  logic [NUM_CH-1:0]            ch_we,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_address,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_datain,
  output logic [NUM_CH-1:0]            ch_grant,
  output logic [NUM_CH-1:0]            ch_rvalid,
  output logic [DATA_WIDTH-1:0]        ch_rdata,
  output logic [ADDR_WIDTH-1:0]        ram_address,
  output logic [DATA_WIDTH-1:0]        ram_datain,
  output logic                         ram_cs,
  output logic                         ram_we,
  input  logic [DATA_WIDTH-1:0]        ram_dataout,
  output logic                         rdy,
  output logic                         halted
);

  typedef enum logic [2:0] {S_LOAD, S_RUN, S_HALTING, S_ARB, S_OWNED, S_RELEASE} state_t;

  localparam int CW = $clog2(HALT_EDGES + 1);
  localparam logic [NUM_CH-1:0] ONE      = {{(NUM_CH-1){1'b0}}, 1'b1};
  localparam logic [NUM_CH-1:0] CPU_MASK = ONE << CPU_CH;

  state_t            state_reg, state_next;
  logic [NUM_CH-1:0] grant_reg, grant_next;
  logic [NUM_CH-1:0] rvalid_reg, rvalid_next;
  logic [NUM_CH-1:0] rr_mask_reg, rr_mask_next;
  logic [CW-1:0]     edge_cnt_reg, edge_cnt_next;
  logic [2:0]        phi2_sync_reg;

  logic              phi2_fall, any_req, owner_req;
  logic [NUM_CH-1:0] req_nc, req_hi, win_pool, win_vec, owner_vec;
  logic [ADDR_WIDTH-1:0] addr_term [NUM_CH];
  logic [DATA_WIDTH-1:0] data_term [NUM_CH];

  assign phi2_fall = phi2_sync_reg[2] & ~phi2_sync_reg[1];
  assign req_nc    = ch_req & ~CPU_MASK;
  assign any_req   = |req_nc;
  assign owner_req = |(grant_reg & ch_req);

  // rr_mask_reg marks channels at or above the search start; an empty hit wraps to the lowest requester
  assign req_hi   = req_nc & rr_mask_reg;
  assign win_pool = (RR_MODE != 0 && req_hi != '0) ? req_hi : req_nc;
  assign win_vec  = win_pool & (-win_pool);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_LOAD;
      grant_reg     <= '0;
      rvalid_reg    <= '0;
      rr_mask_reg   <= '1;
      edge_cnt_reg  <= '0;
      phi2_sync_reg <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rvalid_reg    <= rvalid_next;
      rr_mask_reg   <= rr_mask_next;
      edge_cnt_reg  <= edge_cnt_next;
      phi2_sync_reg <= {phi2_sync_reg[1:0], phi2};
    end
  end

  always_comb begin
    state_next    = state_reg;
    grant_next    = grant_reg;
    rr_mask_next  = rr_mask_reg;
    edge_cnt_next = edge_cnt_reg;
    unique case (state_reg)
      S_LOAD: begin
        if (load_done) begin
          state_next = S_RUN;
        end else if (any_req) begin
          grant_next   = win_vec;
          rr_mask_next = ~((win_vec << 1) - ONE);
          state_next   = S_OWNED;
        end
      end
      S_RUN: begin
        if (any_req) state_next = S_HALTING;
      end
      S_HALTING: begin
        if (!any_req) begin
          state_next    = S_RUN;
          edge_cnt_next = '0;
        end else if (phi2_fall) begin
          if (edge_cnt_reg == CW'(HALT_EDGES - 1)) begin
            state_next    = S_ARB;
            edge_cnt_next = '0;
          end else begin
            edge_cnt_next = edge_cnt_reg + CW'(1);
          end
        end
      end
      S_ARB: begin
        if (any_req) begin
          grant_next   = win_vec;
          rr_mask_next = ~((win_vec << 1) - ONE);
          state_next   = S_OWNED;
        end else begin
          state_next = load_done ? S_RUN : S_LOAD;
        end
      end
      S_OWNED: begin
        if (!owner_req) begin
          grant_next = '0;
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (any_req) state_next = S_ARB;
        else         state_next = load_done ? S_RUN : S_LOAD;
      end
      default: state_next = S_LOAD;
    endcase
  end

  always_comb begin
    owner_vec = grant_reg;
    if (grant_reg == '0 && state_reg == S_RUN) owner_vec = CPU_MASK;
    rdy    = (state_reg == S_RUN);
    halted = load_done && (state_reg inside {S_ARB, S_OWNED, S_RELEASE});
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_mux
      assign addr_term[gi] = owner_vec[gi] ? ch_address[gi*ADDR_WIDTH +: ADDR_WIDTH] : '0;
      assign data_term[gi] = owner_vec[gi] ? ch_datain[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    ram_address = '0;
    ram_datain  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ram_address = ram_address | addr_term[i];
      ram_datain  = ram_datain | data_term[i];
    end
  end

  assign ram_cs      = |(owner_vec & ch_cs);
  assign ram_we      = |(owner_vec & ch_we);
  assign rvalid_next = (ram_cs && !ram_we) ? owner_vec : '0;
  assign ch_grant    = grant_reg;
  assign ch_rvalid   = rvalid_reg;
  assign ch_rdata    = ram_dataout;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a 3-channel instance on a RAM model, plus two 4-channel
// instances (fixed priority and round-robin) for grant ordering.
module tb_ram_port_arbiter;

  typedef struct {int ch; logic [7:0] data;} rd_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic load_done = 1'b0;
  logic phi2 = 1'b0;
  logic [2:0]  ch_req = '0, ch_cs = '0, ch_we = '0;
  logic [47:0] ch_address = '0;
  logic [23:0] ch_datain = '0;
  logic [2:0]  ch_grant, ch_rvalid;
  logic [7:0]  ch_rdata, ram_datain, ram_dataout;
  logic [15:0] ram_address;
  logic        ram_cs, ram_we, rdy, halted;
  logic [7:0]  mem [0:65535];

  logic        p_load_done = 1'b0, p_phi2 = 1'b0;
  logic [3:0]  fp_req = '0, rr_req = '0;
  logic [63:0] p_address = '0;
  logic [31:0] p_datain = '0;
  logic [7:0]  p_dataout = '0;
  logic [3:0]  fp_grant, fp_rvalid, rr_grant, rr_rvalid;
  logic [7:0]  fp_rdata, rr_rdata, fp_ram_datain, rr_ram_datain;
  logic [15:0] fp_ram_address, rr_ram_address;
  logic        fp_ram_cs, fp_ram_we, fp_rdy, fp_halted;
  logic        rr_ram_cs, rr_ram_we, rr_rdy, rr_halted;

  int pass_cnt = 0;
  int total_cnt = 0;
  rd_exp_t rd_q[$];
  int fp_q[$];
  int rr_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) mem[ram_address] <= ram_datain;
      else        ram_dataout <= mem[ram_address];
    end
  end

  ram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_CH(3), .CPU_CH(1), .RR_MODE(0), .HALT_EDGES(2)) dut (
    .clk(clk), .reset(reset), .load_done(load_done), .phi2(phi2),
    .ch_req(ch_req), .ch_cs(ch_cs), .ch_we(ch_we), .ch_address(ch_address), .ch_datain(ch_datain),
    .ch_grant(ch_grant), .ch_rvalid(ch_rvalid), .ch_rdata(ch_rdata),
    .ram_address(ram_address), .ram_datain(ram_datain), .ram_cs(ram_cs), .ram_we(ram_we),
    .ram_dataout(ram_dataout), .rdy(rdy), .halted(halted));

  ram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_CH(4), .CPU_CH(1), .RR_MODE(0), .HALT_EDGES(2)) dut_fp (
    .clk(clk), .reset(reset), .load_done(p_load_done), .phi2(p_phi2),
    .ch_req(fp_req), .ch_cs(fp_req), .ch_we(4'hF), .ch_address(p_address), .ch_datain(p_datain),
    .ch_grant(fp_grant), .ch_rvalid(fp_rvalid), .ch_rdata(fp_rdata),
    .ram_address(fp_ram_address), .ram_datain(fp_ram_datain), .ram_cs(fp_ram_cs), .ram_we(fp_ram_we),
    .ram_dataout(p_dataout), .rdy(fp_rdy), .halted(fp_halted));

  ram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .NUM_CH(4), .CPU_CH(1), .RR_MODE(1), .HALT_EDGES(2)) dut_rr (
    .clk(clk), .reset(reset), .load_done(p_load_done), .phi2(p_phi2),
    .ch_req(rr_req), .ch_cs(rr_req), .ch_we(4'hF), .ch_address(p_address), .ch_datain(p_datain),
    .ch_grant(rr_grant), .ch_rvalid(rr_rvalid), .ch_rdata(rr_rdata),
    .ram_address(rr_ram_address), .ram_datain(rr_ram_datain), .ram_cs(rr_ram_cs), .ram_we(rr_ram_we),
    .ram_dataout(p_dataout), .rdy(rr_rdy), .halted(rr_halted));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic phi2_pulse();
    phi2 = 1'b1;
    repeat (3) tick();
    phi2 = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    repeat (2) tick();
    total_cnt++; if (ch_grant !== 3'b000) $display("FAIL reset_grant: got %b expected 000", ch_grant); else pass_cnt++;
    total_cnt++; if (ch_rvalid !== 3'b000) $display("FAIL reset_rvalid: got %b expected 000", ch_rvalid); else pass_cnt++;
    total_cnt++; if ({rdy, halted, ram_cs, ram_we} !== 4'b0000) $display("FAIL reset_ctrl: got %b expected 0000", {rdy, halted, ram_cs, ram_we}); else pass_cnt++;
    total_cnt++; if ({ram_address, ram_datain} !== 24'h0) $display("FAIL reset_port: got %h expected 000000", {ram_address, ram_datain}); else pass_cnt++;
    reset = 1'b1;
    tick();
    total_cnt++; if ({rdy, ch_grant} !== 4'b0000) $display("FAIL reset_idle: got %b expected 0000", {rdy, ch_grant}); else pass_cnt++;
  endtask

  task automatic test_load();
    ch_req = 3'b001; ch_cs = 3'b001; ch_we = 3'b001;
    ch_address[0 +: 16] = 16'h1234; ch_datain[0 +: 8] = 8'hA5;
    tick();
    total_cnt++; if (ch_grant !== 3'b001) $display("FAIL load_grant: got %b expected 001", ch_grant); else pass_cnt++;
    total_cnt++; if ({ram_cs, ram_we, ram_address, ram_datain} !== {2'b11, 16'h1234, 8'hA5}) $display("FAIL load_port: got cs=%b we=%b a=%h d=%h expected 1 1 1234 a5", ram_cs, ram_we, ram_address, ram_datain); else pass_cnt++;
    total_cnt++; if (rdy !== 1'b0) $display("FAIL load_rdy_owned: got %b expected 0", rdy); else pass_cnt++;
    tick();
    ch_req = '0; ch_cs = '0; ch_we = '0; load_done = 1'b1;
    tick();
    total_cnt++; if ({ch_grant, ram_cs, rdy} !== 5'b00000) $display("FAIL load_release: got grant=%b cs=%b rdy=%b expected 000 0 0", ch_grant, ram_cs, rdy); else pass_cnt++;
    tick();
    total_cnt++; if (rdy !== 1'b1) $display("FAIL load_run_rdy: got %b expected 1", rdy); else pass_cnt++;
  endtask

  task automatic test_halt();
    int n;
    rd_exp_t e;
    ch_address[32 +: 16] = 16'h1234; ch_cs = 3'b100; ch_we = '0; ch_req = 3'b100;
    tick();
    total_cnt++; if ({rdy, ch_grant} !== 4'b0000) $display("FAIL halt_rdy_drop: got rdy=%b grant=%b expected 0 000", rdy, ch_grant); else pass_cnt++;
    phi2_pulse();
    total_cnt++; if ({rdy, ch_grant} !== 4'b0000) $display("FAIL halt_one_edge: got rdy=%b grant=%b expected 0 000", rdy, ch_grant); else pass_cnt++;
    phi2 = 1'b1;
    repeat (3) tick();
    total_cnt++; if (ch_grant !== 3'b000) $display("FAIL halt_early_grant: got %b expected 000", ch_grant); else pass_cnt++;
    phi2 = 1'b0;
    n = 0;
    while (ch_grant === 3'b000 && n < 10) begin
      tick();
      n++;
    end
    total_cnt++; if (ch_grant !== 3'b100) $display("FAIL halt_grant: got %b expected 100 after %0d clk", ch_grant, n); else pass_cnt++;
    total_cnt++; if ({halted, rdy} !== 2'b10) $display("FAIL halt_flags: got halted=%b rdy=%b expected 1 0", halted, rdy); else pass_cnt++;
    rd_q.push_back('{2, 8'hA5});
    tick();
    ch_cs = '0;
    if (ch_rvalid != 3'b000 && rd_q.size() != 0) begin
      e = rd_q.pop_front();
      total_cnt++; if (ch_rvalid !== (3'b001 << e.ch) || ch_rdata !== e.data) $display("FAIL halt_read: got rvalid=%b data=%h expected ch%0d %h", ch_rvalid, ch_rdata, e.ch, e.data); else pass_cnt++;
    end else begin
      total_cnt++; $display("FAIL halt_read: got rvalid=%b expected 100", ch_rvalid);
    end
    tick();
    total_cnt++; if ({ch_rvalid, ram_cs, ch_grant} !== 7'b0000100) $display("FAIL halt_idle_owned: got rvalid=%b cs=%b grant=%b expected 000 0 100", ch_rvalid, ram_cs, ch_grant); else pass_cnt++;
  endtask

  task automatic test_release();
    rd_exp_t e;
    ch_req = '0; ch_cs = 3'b010; ch_we = '0; ch_address[16 +: 16] = 16'h1234;
    tick();
    total_cnt++; if ({ch_grant, ram_cs, rdy, halted} !== 6'b000001) $display("FAIL release_dead: got grant=%b cs=%b rdy=%b halted=%b expected 000 0 0 1", ch_grant, ram_cs, rdy, halted); else pass_cnt++;
    tick();
    total_cnt++; if ({rdy, ram_cs, ram_address} !== {2'b11, 16'h1234}) $display("FAIL release_cpu: got rdy=%b cs=%b a=%h expected 1 1 1234", rdy, ram_cs, ram_address); else pass_cnt++;
    rd_q.push_back('{1, 8'hA5});
    tick();
    ch_cs = '0;
    if (ch_rvalid != 3'b000 && rd_q.size() != 0) begin
      e = rd_q.pop_front();
      total_cnt++; if (ch_rvalid !== (3'b001 << e.ch) || ch_rdata !== e.data) $display("FAIL cpu_read: got rvalid=%b data=%h expected ch%0d %h", ch_rvalid, ch_rdata, e.ch, e.data); else pass_cnt++;
    end else begin
      total_cnt++; $display("FAIL cpu_read: got rvalid=%b expected 010", ch_rvalid);
    end
    total_cnt++; if (halted !== 1'b0) $display("FAIL run_halted: got %b expected 0", halted); else pass_cnt++;
  endtask

  task automatic test_abandon();
    ch_req = 3'b100; ch_cs = '0;
    tick();
    phi2_pulse();
    total_cnt++; if ({rdy, ch_grant} !== 4'b0000) $display("FAIL abandon_wait: got rdy=%b grant=%b expected 0 000", rdy, ch_grant); else pass_cnt++;
    ch_req = '0;
    tick();
    total_cnt++; if ({rdy, ch_grant} !== 4'b1000) $display("FAIL abandon_run: got rdy=%b grant=%b expected 1 000", rdy, ch_grant); else pass_cnt++;
    tick();
    total_cnt++; if ({rdy, ch_grant} !== 4'b1000) $display("FAIL abandon_hold: got rdy=%b grant=%b expected 1 000", rdy, ch_grant); else pass_cnt++;
  endtask

  task automatic test_priority();
    int n, ex;
    logic [3:0] fp_prev, rr_prev, e1h;
    fp_q = '{0, 0, 0, 0, 0, 0};
    rr_q = '{0, 2, 3, 0, 2, 3};
    fp_prev = fp_grant; rr_prev = rr_grant;
    fp_req = 4'b1101; rr_req = 4'b1101;
    n = 0;
    while ((fp_q.size() != 0 || rr_q.size() != 0) && n < 60) begin
      tick();
      n++;
      if (fp_grant != 4'b0000 && fp_prev == 4'b0000 && fp_q.size() != 0) begin
        ex = fp_q.pop_front(); e1h = 4'b0001 << ex;
        total_cnt++; if (fp_grant !== e1h) $display("FAIL fixed_order: got %b expected %b", fp_grant, e1h); else pass_cnt++;
      end
      if (rr_grant != 4'b0000 && rr_prev == 4'b0000 && rr_q.size() != 0) begin
        ex = rr_q.pop_front(); e1h = 4'b0001 << ex;
        total_cnt++; if (rr_grant !== e1h) $display("FAIL rr_order: got %b expected %b", rr_grant, e1h); else pass_cnt++;
      end
      fp_prev = fp_grant; rr_prev = rr_grant;
      fp_req = 4'b1101 & ~fp_grant;
      rr_req = 4'b1101 & ~rr_grant;
    end
    total_cnt++; if (fp_q.size() + rr_q.size() != 0) $display("FAIL priority_timeout: got %0d grants pending expected 0", fp_q.size() + rr_q.size()); else pass_cnt++;
    total_cnt++; if ({fp_rdy, rr_rdy, fp_halted, rr_halted} !== 4'b0000) $display("FAIL priority_load_flags: got %b expected 0000", {fp_rdy, rr_rdy, fp_halted, rr_halted}); else pass_cnt++;
    fp_req = '0; rr_req = '0;
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    load_done = 1'b0;
    ch_req = 3'b001; ch_cs = 3'b001; ch_we = '0; ch_address[0 +: 16] = 16'h1234;
    tick();
    total_cnt++; if (ch_grant !== 3'b001) $display("FAIL mid_grant: got %b expected 001", ch_grant); else pass_cnt++;
    tick();
    total_cnt++; if (ch_rvalid !== 3'b001 || ch_rdata !== 8'hA5) $display("FAIL mid_read: got rvalid=%b data=%h expected 001 a5", ch_rvalid, ch_rdata); else pass_cnt++;
    #3;
    reset = 1'b0;
    #1;
    total_cnt++; if ({ch_grant, ch_rvalid, ram_cs, rdy, halted} !== 9'b0) $display("FAIL mid_async: got grant=%b rvalid=%b cs=%b rdy=%b halted=%b expected all 0", ch_grant, ch_rvalid, ram_cs, rdy, halted); else pass_cnt++;
    tick();
    total_cnt++; if ({ch_grant, ch_rvalid} !== 6'b0) $display("FAIL mid_held: got grant=%b rvalid=%b expected 000 000", ch_grant, ch_rvalid); else pass_cnt++;
    reset = 1'b1;
    tick();
    total_cnt++; if ({ch_grant, rdy} !== 4'b0010) $display("FAIL mid_load_state: got grant=%b rdy=%b expected 001 0", ch_grant, rdy); else pass_cnt++;
    ch_req = '0; ch_cs = '0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_halt();
    test_release();
    test_abandon();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
